man_mul_arbiter: RTL and testbench

Round-robin sequencer that shares one 24×24 mantissa multiplier between two FP32 multiply requesters (e.g. two FP_32/MUL lanes). It accepts hidden-bit-extended mantissa pairs over valid/ready handshakes and pipelines the accepted operands through a single multiplier. It normalises each product to 24 bits plus an exponent-increment flag and returns the result to the originating requester with fixed latency.

---
 rtl/man_mul_arbiter_if.sv | 35 +++
 rtl/man_mul_arbiter.sv | 124 ++++++++++++
 tb/tb_man_mul_arbiter.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/man_mul_arbiter_if.sv
// Requester/response bundle between two FP32 multiply lanes and the shared
// mantissa multiplier sequencer. The master modport is the requester side.
interface man_mul_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [23:0] req0_f1;
    logic [23:0] req0_f2;
    logic        req1_valid;
    logic        req1_ready;
    logic [23:0] req1_f1;
    logic [23:0] req1_f2;

    logic        rsp0_valid;
    logic [23:0] rsp0_man;
    logic        rsp0_exp_add;
    logic        rsp1_valid;
    logic [23:0] rsp1_man;
    logic        rsp1_exp_add;

    modport master (
        output req0_valid, req0_f1, req0_f2,
        output req1_valid, req1_f1, req1_f2,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_man, rsp0_exp_add,
        input  rsp1_valid, rsp1_man, rsp1_exp_add
    );

    modport slave (
        input  req0_valid, req0_f1, req0_f2,
        input  req1_valid, req1_f1, req1_f2,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_man, rsp0_exp_add,
        output rsp1_valid, rsp1_man, rsp1_exp_add
    );
endinterface

// File: rtl/man_mul_arbiter.sv
// Round-robin sharing of one 24x24 mantissa multiplier between two requesters,
// two-stage pipeline, fixed latency. Define MAN_MUL_ROUND_RNE_EN for RNE rounding.
module man_mul_arbiter (
    input logic              clk,
    input logic              rst,
    man_mul_arbiter_if.slave bus
);

    logic        prio;
    logic        prio_next;
    logic        grant0;
    logic        grant1;
    logic        xfer;

    logic        s1_valid;
    logic        s1_id;
    logic [23:0] s1_f1;
    logic [23:0] s1_f2;

    logic        s2_valid;
    logic        s2_id;
`ifdef MAN_MUL_ROUND_RNE_EN
    logic [47:0] s2_prod;
`else
    // Truncation only needs p[47:23]; the lower product bits are never stored.
    logic [24:0] s2_prod;
`endif

    logic [23:0] norm_man;
    logic        norm_exp_add;

    always_ff @(posedge clk) begin
        if (rst) begin
            prio <= 1'b0;
        end else begin
            prio <= prio_next;
        end
    end

    // After a transfer the requester that was not served becomes favoured.
    always_comb begin
        prio_next = prio;
        if (xfer) begin
            prio_next = grant0;
        end
    end

    always_comb begin
        grant0         = bus.req0_valid && (!bus.req1_valid || !prio);
        grant1         = bus.req1_valid && (!bus.req0_valid ||  prio);
        xfer           = grant0 || grant1;
        bus.req0_ready = grant0;
        bus.req1_ready = grant1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_id    <= 1'b0;
            s1_f1    <= '0;
            s1_f2    <= '0;
            s2_valid <= 1'b0;
            s2_id    <= 1'b0;
            s2_prod  <= '0;
        end else begin
            s1_valid <= xfer;
            if (xfer) begin
                s1_id <= grant1;
                s1_f1 <= grant1 ? bus.req1_f1 : bus.req0_f1;
                s1_f2 <= grant1 ? bus.req1_f2 : bus.req0_f2;
            end
            s2_valid <= s1_valid;
            s2_id    <= s1_id;
`ifdef MAN_MUL_ROUND_RNE_EN
            s2_prod  <= {24'd0, s1_f1} * {24'd0, s1_f2};
`else
            s2_prod  <= 25'(({24'd0, s1_f1} * {24'd0, s1_f2}) >> 23);
`endif
        end
    end

`ifdef MAN_MUL_ROUND_RNE_EN
    logic [23:0] man_trunc;
    logic        guard;
    logic        sticky;
    logic [24:0] man_round;

    // Round-to-nearest-even; a carry out of 24 bits renormalises to 1.0 x 2.
    always_comb begin
        norm_exp_add = s2_prod[47];
        if (s2_prod[47]) begin
            man_trunc = s2_prod[47:24];
            guard     = s2_prod[23];
            sticky    = |s2_prod[22:0];
        end else begin
            man_trunc = s2_prod[46:23];
            guard     = s2_prod[22];
            sticky    = |s2_prod[21:0];
        end
        man_round = {1'b0, man_trunc} + 25'(guard && (sticky || man_trunc[0]));
        if (man_round[24]) begin
            norm_man     = 24'h800000;
            norm_exp_add = 1'b1;
        end else begin
            norm_man     = man_round[23:0];
        end
    end
`else
    always_comb begin
        norm_exp_add = s2_prod[24];
        norm_man     = s2_prod[24] ? s2_prod[24:1] : s2_prod[23:0];
    end
`endif

    always_comb begin
        bus.rsp0_valid   = s2_valid && !s2_id;
        bus.rsp1_valid   = s2_valid &&  s2_id;
        bus.rsp0_man     = norm_man;
        bus.rsp1_man     = norm_man;
        bus.rsp0_exp_add = norm_exp_add;
        bus.rsp1_exp_add = norm_exp_add;
    end

endmodule

// File: tb/tb_man_mul_arbiter.sv
// Scoreboard bench for man_mul_arbiter: a reference grant/arithmetic model
// queues expected responses per requester and checks them on arrival.
module tb_man_mul_arbiter;

    typedef struct {
        logic [23:0] man;
        logic        exp_add;
        int          due;
    } exp_t;

    logic clk;
    logic rst;
    man_mul_arbiter_if bus();

    man_mul_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    exp_t q0[$];
    exp_t q1[$];
    int   errors;
    int   checks;
    int   cyc;
    logic mprio;
    logic idle_zero;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Reference: exact 48-bit product, normalise, optional round-to-nearest-even.
    function automatic exp_t model(input logic [23:0] a, input logic [23:0] b);
        exp_t        e;
        logic [63:0] p;
        logic [63:0] m;
        logic        g;
        logic        s;
        p = 64'(a) * 64'(b);
        e.exp_add = p[47];
        if (p[47]) begin
            m = p >> 24;
            g = p[23];
            s = (p & 64'h7FFFFF) != 0;
        end else begin
            m = p >> 23;
            g = p[22];
            s = (p & 64'h3FFFFF) != 0;
        end
`ifdef MAN_MUL_ROUND_RNE_EN
        if (g && (s || m[0])) m = m + 1;
        if (m == 64'h1000000) begin
            m = 64'h800000;
            e.exp_add = 1'b1;
        end
`else
        if (g && s) m = m + 0;
`endif
        e.man = m[23:0];
        e.due = 0;
        return e;
    endfunction

    task automatic monitorResponses();
        logic exp0;
        logic exp1;
        exp0 = (q0.size() > 0) && (q0[0].due == cyc);
        exp1 = (q1.size() > 0) && (q1[0].due == cyc);
        checkOutput("rsp0_valid", 48'(bus.rsp0_valid), 48'(exp0));
        checkOutput("rsp1_valid", 48'(bus.rsp1_valid), 48'(exp1));
        if (exp0) begin
            checkOutput("rsp0_man", 48'(bus.rsp0_man), 48'(q0[0].man));
            checkOutput("rsp0_exp_add", 48'(bus.rsp0_exp_add), 48'(q0[0].exp_add));
            checkOutput("rsp1_man_shared", 48'(bus.rsp1_man), 48'(q0[0].man));
            void'(q0.pop_front());
        end
        if (exp1) begin
            checkOutput("rsp1_man", 48'(bus.rsp1_man), 48'(q1[0].man));
            checkOutput("rsp1_exp_add", 48'(bus.rsp1_exp_add), 48'(q1[0].exp_add));
            checkOutput("rsp0_man_shared", 48'(bus.rsp0_man), 48'(q1[0].man));
            void'(q1.pop_front());
        end
        if (idle_zero) begin
            checkOutput("idle_rsp0_man", 48'(bus.rsp0_man), 48'd0);
            checkOutput("idle_rsp1_man", 48'(bus.rsp1_man), 48'd0);
            checkOutput("idle_rsp0_exp_add", 48'(bus.rsp0_exp_add), 48'd0);
            checkOutput("idle_rsp1_exp_add", 48'(bus.rsp1_exp_add), 48'd0);
        end
    endtask

    // One clock cycle: check responses, drive inputs, check grants, then model the edge.
    task automatic applyStimulus(input logic r,
                                 input logic v0, input logic [23:0] a0, input logic [23:0] b0,
                                 input logic v1, input logic [23:0] a1, input logic [23:0] b1);
        logic g0;
        logic g1;
        exp_t e;
        @(negedge clk);
        monitorResponses();
        rst            = r;
        bus.req0_valid = v0;
        bus.req0_f1    = a0;
        bus.req0_f2    = b0;
        bus.req1_valid = v1;
        bus.req1_f1    = a1;
        bus.req1_f2    = b1;
        #1;
        g0 = v0 && (!v1 || !mprio);
        g1 = v1 && (!v0 ||  mprio);
        if (!r) begin
            checkOutput("req0_ready", 48'(bus.req0_ready), 48'(g0));
            checkOutput("req1_ready", 48'(bus.req1_ready), 48'(g1));
        end
        @(posedge clk);
        cyc++;
        if (r) begin
            q0.delete();
            q1.delete();
            mprio = 1'b0;
        end else if (g0 || g1) begin
            e     = g1 ? model(a1, b1) : model(a0, b0);
            e.due = cyc + 1;
            if (g1) q1.push_back(e);
            else    q0.push_back(e);
            mprio = g0;
        end
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 24'd0, 24'd0, 1'b0, 24'd0, 24'd0);
    endtask

    task automatic resetCycle();
        applyStimulus(1'b1, 1'b0, 24'd0, 24'd0, 1'b0, 24'd0, 24'd0);
    endtask

    initial begin
        errors         = 0;
        checks         = 0;
        cyc            = 0;
        mprio          = 1'b0;
        idle_zero      = 1'b0;
        rst            = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req0_f1    = '0;
        bus.req0_f2    = '0;
        bus.req1_valid = 1'b0;
        bus.req1_f1    = '0;
        bus.req1_f2    = '0;

        resetCycle();
        resetCycle();
        idle_zero = 1'b1;
        idleCycles(5);
        idle_zero = 1'b0;

        applyStimulus(1'b0, 1'b1, 24'h800000, 24'h800000, 1'b0, 24'd0, 24'd0);
        idleCycles(3);
        applyStimulus(1'b0, 1'b1, 24'hC00000, 24'hC00000, 1'b0, 24'd0, 24'd0);
        idleCycles(3);

        // Contention from a fresh reset: grants must alternate starting with req0.
        resetCycle();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b1, 24'h800000 + 24'(i * 24'h111111), 24'hA00000 + 24'(i),
                                1'b1, 24'hF00000 - 24'(i * 24'h030303), 24'hC00001 + 24'(i * 7));
        end
        idleCycles(3);

        applyStimulus(1'b0, 1'b0, 24'd0, 24'd0, 1'b1, 24'hC00001, 24'hC00001);
        applyStimulus(1'b0, 1'b1, 24'hFFFFFF, 24'hFFFFFF, 1'b0, 24'd0, 24'd0);
        applyStimulus(1'b0, 1'b0, 24'd0, 24'd0, 1'b1, 24'hFFFFFF, 24'hFFFFFF);
        applyStimulus(1'b0, 1'b1, 24'h000003, 24'h400000, 1'b0, 24'd0, 24'd0);
        idleCycles(3);

        // Reset right after two back-to-back transfers drops the second one.
        applyStimulus(1'b0, 1'b1, 24'h900000, 24'h900000, 1'b0, 24'd0, 24'd0);
        applyStimulus(1'b0, 1'b0, 24'd0, 24'd0, 1'b1, 24'hB00000, 24'hB00000);
        applyStimulus(1'b1, 1'b1, 24'hC00000, 24'hC00000, 1'b1, 24'hD00000, 24'hD00000);
        applyStimulus(1'b0, 1'b1, 24'hE00000, 24'h800001, 1'b1, 24'h8FFFFF, 24'hFFFFFF);
        applyStimulus(1'b0, 1'b1, 24'hE00000, 24'h800001, 1'b1, 24'h8FFFFF, 24'hFFFFFF);
        idleCycles(3);

        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b0, 1'($urandom_range(0, 1)), 24'h800000 | 24'($urandom), 24'h800000 | 24'($urandom),
                                1'($urandom_range(0, 1)), 24'h800000 | 24'($urandom), 24'h800000 | 24'($urandom));
        end
        idleCycles(4);

        checkOutput("drain_q0", 48'(q0.size()), 48'd0);
        checkOutput("drain_q1", 48'(q1.size()), 48'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
